uart_rx_read: RTL and testbench

- Receive-side companion to the TX write path; consumes the serial `tx` line produced by the transmit chain (loopback or external link).
- Deserialises 8N1 UART frames with mid-bit sampling and buffers received bytes in an internal FIFO.
- Presents bytes to the consumer through a valid/ready handshake, and reports framing-error and overrun events.

---
 rtl/uart_rx_read.sv | 156 +++++++++++++++
 tb/tb_uart_rx_read.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_read.sv
// 8N1 UART receiver: mid-bit sampling deserialiser feeding a first-word-fall-through
// FIFO with valid/ready output, plus one-cycle framing-error and overrun pulses.
module uart_rx_read #(
    parameter int DATA_WIDTH   = 8,
    parameter int BAUDRATE     = 9600,
    parameter int CLK_FREQ_MHZ = 125,
    parameter int FIFO_AW      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  frame_err,
    output logic                  overrun,
    output logic [FIFO_AW:0]      fifo_count
);

    localparam int CPB   = (CLK_FREQ_MHZ * 1_000_000) / BAUDRATE;
    localparam int HALF  = CPB / 2;
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CNT_W = $clog2(CPB + 1);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CPB_M1  = CNT_W'(CPB - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    rx_meta_q, rx_s_q, rx_prev_q;
    logic                    ferr_q, ferr_d;
    logic                    ovr_q, ovr_d;
    logic                    push;
    logic                    pop;
    logic                    push_ok;
    logic                    fall;
    logic [FIFO_AW:0]        wptr_q, rptr_q;
    logic [FIFO_AW:0]        count;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    // Synchroniser and edge-detect flops idle high so reset never fakes a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign fall = rx_prev_q & ~rx_s_q;

    assign count      = wptr_q - rptr_q;
    assign valid_out  = (count != '0);
    assign pop        = valid_out & ready_out;
    assign push_ok    = ~count[FIFO_AW] | pop;
    assign fifo_count = count;
    assign rx_data    = valid_out ? mem_q[rptr_q[FIFO_AW-1:0]] : '0;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        push    = 1'b0;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (fall) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == CPB_M1) begin
                    cnt_d           = '0;
                    shift_d[idx_q]  = rx_s_q;
                    idx_d           = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == CPB_M1) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                        if (push_ok) push  = 1'b1;
                        else         ovr_d = 1'b1;
                    end else begin
                        state_d = S_BREAK;
                        ferr_d  = 1'b1;
                    end
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rx_s_q) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            if (push) wptr_q <= wptr_q + (FIFO_AW+1)'(1);
            if (pop)  rptr_q <= rptr_q + (FIFO_AW+1)'(1);
        end
    end

    // Storage carries no reset; rx_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[FIFO_AW-1:0]] <= shift_q;
    end

endmodule

// File: tb/tb_uart_rx_read.sv
// Bench for uart_rx_read: drives 8N1 frames at 10 clk/bit against a frame-level model.
module tb_uart_rx_read;

    localparam int CPB = 10;
    localparam int DEP = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       ready_out = 1'b0;
    logic       valid_out;
    logic [7:0] rx_data;
    logic       frame_err;
    logic       overrun;
    logic [2:0] fifo_count;

    int checks = 0;
    int failures = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int ferr_cnt = 0, ovr_cnt = 0;
    int exp_ferr = 0, exp_ovr = 0;
    int m_occ = 0;

    uart_rx_read #(
        .DATA_WIDTH(8),
        .BAUDRATE(100000),
        .CLK_FREQ_MHZ(1),
        .FIFO_AW(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .valid_out(valid_out),
        .ready_out(ready_out),
        .rx_data(rx_data),
        .frame_err(frame_err),
        .overrun(overrun),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Observer: records accepted bytes and flag pulses away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_out && ready_out) got_q.push_back(rx_data);
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    // Frame-level model: good frames enter the buffer unless it is full and not draining.
    task automatic frame(input logic [7:0] b, input logic stop);
        send_frame(b, stop);
        if (!stop) exp_ferr++;
        else if (ready_out || m_occ < DEP) begin
            exp_q.push_back(b);
            if (!ready_out) m_occ++;
        end else exp_ovr++;
    endtask

    task automatic drain();
        ready_out = 1'b1;
        tick(2 * m_occ + 4);
        m_occ = 0;
    endtask

    task automatic compare(input string tag);
        check({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
        check({tag, "_ferr"}, ferr_cnt, exp_ferr);
        check({tag, "_ovr"}, ovr_cnt, exp_ovr);
        got_q.delete();
        exp_q.delete();
        ferr_cnt = 0; ovr_cnt = 0; exp_ferr = 0; exp_ovr = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, valid_out, 0);
        check({tag, "_data"}, rx_data, 0);
        check({tag, "_ferr"}, frame_err, 0);
        check({tag, "_ovr"}, overrun, 0);
        check({tag, "_count"}, fifo_count, 0);
    endtask

    initial begin
        logic [7:0] b;
        logic       st;
        int         n;

        // Reset state
        tick(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick(5);

        // Single frame with consumer ready
        ready_out = 1'b1;
        frame(8'hA5, 1'b1);
        tick(5);
        check("a5_count", fifo_count, 0);
        compare("a5");

        // Short low glitch is rejected, next frame still received
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(30);
        compare("glitch");
        frame(8'h3C, 1'b1);
        tick(5);
        compare("after_glitch");

        // Bad stop bit followed by a held-low break
        frame(8'h55, 1'b0);
        rx = 1'b0;
        tick(50);
        rx = 1'b1;
        tick(20);
        frame(8'h0F, 1'b1);
        tick(5);
        compare("break");

        // Fill with consumer stalled: fifth frame overruns
        ready_out = 1'b0;
        for (int i = 1; i <= 5; i++) frame(8'(i), 1'b1);
        tick(5);
        check("ovr_count", fifo_count, 4);
        check("ovr_valid", valid_out, 1);
        drain();
        compare("overrun");

        // Full buffer, pop on the exact stop-sample cycle: no overrun, order kept across wrap
        ready_out = 1'b0;
        for (int i = 0; i < 4; i++) frame(8'($urandom_range(0, 255)), 1'b1);
        b = 8'($urandom_range(0, 255));
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        rx = 1'b1;
        tick(7);
        ready_out = 1'b1;
        tick(1);
        ready_out = 1'b0;
        check("swap_count", fifo_count, 4);
        exp_q.push_back(b);
        tick(4);
        check("swap_count_hold", fifo_count, 4);
        drain();
        compare("swap");

        // Randomized batches with random stalls and occasional bad stop bits
        for (int r = 0; r < 4; r++) begin
            ready_out = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 5);
            for (int k = 0; k < n; k++) begin
                b  = 8'($urandom_range(0, 255));
                st = ($urandom_range(0, 3) != 0);
                frame(b, st);
                rx = 1'b1;
                tick($urandom_range(12, 25));
            end
            check($sformatf("rnd%0d_count", r), fifo_count, m_occ);
            drain();
            compare($sformatf("rnd%0d", r));
        end

        // Reset in the middle of a frame, with a byte already buffered
        ready_out = 1'b0;
        frame(8'h11, 1'b1);
        tick(3);
        check("prerst_count", fifo_count, 1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rx = 1'b0;
        tick(5);
        rst = 1'b1;
        rx  = 1'b1;
        #1;
        check_reset_outputs("midrst");
        tick(4);
        check_reset_outputs("midrst_hold");
        exp_q.delete();
        m_occ = 0;
        rst = 1'b0;
        tick(5);
        ready_out = 1'b1;
        frame(8'h7E, 1'b1);
        tick(5);
        compare("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
